// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/word load-store sequencer for a byte-wide data memory
//
// Splits each core access into one or two single-byte memory cycles (low byte
// at Addr, high byte at Addr+1, little-endian) and returns a completion pulse.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-low reset
//   Start             request strobe, only honoured in IDLE
//   IsStore, Size,    access attributes, captured together with Start
//   SignExt, Addr,
//   WrData
//   Busy, Done        access in progress / one-cycle completion pulse
//   RdData            load result, valid from Done until the next load
//   MemRead/MemWrite  memory enables (never both high)
//   Byte              memory lane select (0 = DataIn[7:0], 1 = DataIn[15:8])
//   DataAddress       memory byte address
//   MemDataIn         memory write data bus
//   MemDataOut        memory read data bus (combinational read path)
module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              IsStore,
  input  logic              Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] RdData,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Byte,
  output logic [ADDR_W-1:0] DataAddress,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              is_store_q, is_store_d;
  logic              size_q, size_d;
  logic              sign_ext_q, sign_ext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              byte_q, byte_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        lo_byte_q, lo_byte_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = S_LO;
      S_LO:   state_d = size_q ? S_HI : S_DONE;
      S_HI:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: enables are decoded from state so reset clears them at once
  always_comb begin
    Busy     = (state_q != S_IDLE);
    Done     = (state_q == S_DONE);
    MemRead  = ((state_q == S_LO) || (state_q == S_HI)) && !is_store_q;
    MemWrite = ((state_q == S_LO) || (state_q == S_HI)) &&  is_store_q;
  end

  // Datapath registers. DataAddress/Byte/MemDataIn are registered so that they
  // are already correct in LO/HI and simply hold their value in IDLE/DONE.
  always_comb begin
    is_store_d = is_store_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    wdata_d    = wdata_q;
    lo_byte_d  = lo_byte_q;
    rd_d       = rd_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          is_store_d = IsStore;
          size_d     = Size;
          sign_ext_d = SignExt;
          addr_d     = Addr;
          byte_d     = 1'b0;
          wdata_d    = WrData;
        end
      end
      S_LO: begin
        if (!is_store_q) begin
          if (size_q) begin
            lo_byte_d = MemDataOut[7:0];
          end else if (sign_ext_q) begin
            rd_d = {{(DATA_W-8){MemDataOut[7]}}, MemDataOut[7:0]};
          end else begin
            rd_d = {{(DATA_W-8){1'b0}}, MemDataOut[7:0]};
          end
        end
        if (size_q) begin
          // Address wraps naturally at 2^ADDR_W
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          byte_d = 1'b1;
        end
      end
      S_HI: begin
        if (!is_store_q) begin
          rd_d       = '0;
          rd_d[15:8] = MemDataOut[15:8];
          rd_d[7:0]  = lo_byte_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      is_store_q <= 1'b0;
      size_q     <= 1'b0;
      sign_ext_q <= 1'b0;
      addr_q     <= '0;
      byte_q     <= 1'b0;
      wdata_q    <= '0;
      lo_byte_q  <= 8'h00;
      rd_q       <= '0;
    end else begin
      is_store_q <= is_store_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
      wdata_q    <= wdata_d;
      lo_byte_q  <= lo_byte_d;
      rd_q       <= rd_d;
    end
  end

  assign DataAddress = addr_q;
  assign Byte        = byte_q;
  assign MemDataIn   = wdata_q;
  assign RdData      = rd_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 8, width of the byte address into the 256-deep byte-wide data memory.
REQ-002 Parameter: DATA_W, default 16, width of the core data path and of the memory DataIn/DataOut buses.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; the block is in reset while Reset==0.
REQ-005 Start  input  1  request strobe from the core, sampled in IDLE only.
REQ-006 IsStore  input  1  1=store, 0=load; captured with Start.
REQ-007 Size  input  1  1=16-bit word, 0=single byte; captured with Start.
REQ-008 SignExt  input  1  for byte loads, 1=sign-extend, 0=zero-extend; captured with Start.
REQ-009 Addr  input  ADDR_W  byte address of the access; captured with Start.
REQ-010 WrData  input  DATA_W  store data; captured with Start.
REQ-011 Busy  output  1  high while an access is in progress (states LO, HI, DONE).
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 RdData  output  DATA_W  load result; valid when Done==1 and held until the next accepted load.
REQ-014 MemRead  output  1  memory read enable.
REQ-015 MemWrite  output  1  memory write enable.
REQ-016 Byte  output  1  memory lane select: 0=low lane DataIn[7:0], 1=high lane DataIn[15:8].
REQ-017 DataAddress  output  ADDR_W  memory byte address.
REQ-018 MemDataIn  output  DATA_W  drives the memory DataIn bus.
REQ-019 MemDataOut  input  DATA_W  memory DataOut bus; the memory's read path is combinational.

Function
REQ-020 State machine SHALL have states IDLE, LO, HI, DONE.
REQ-021 IDLE: Start==1 captures IsStore, Size, SignExt, Addr, WrData and moves to LO; Start==0 stays in IDLE.
REQ-022 LO: DataAddress=Addr, Byte=0, MemDataIn=captured WrData.
- Store: MemWrite=1, MemRead=0; the memory writes WrData[7:0] at Addr on this edge.
- Load: MemRead=1, MemWrite=0; MemDataOut[7:0] is registered into the result low byte on this edge.
- Next state: HI if Size==1, else DONE.
REQ-023 HI: DataAddress=Addr+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00), Byte=1, MemDataIn=captured WrData.
- Store: MemWrite=1; the memory writes WrData[15:8].
- Load: MemRead=1; MemDataOut[15:8] is registered into the result high byte.
- Next state: DONE.
REQ-024 DONE: Done=1 for exactly one cycle, MemRead=MemWrite=0, next state IDLE.
REQ-025 Word layout SHALL be little-endian: low byte at Addr, high byte at Addr+1.
REQ-026 Byte load result SHALL be {8{b[7]},b} when SignExt==1, else {8'h00,b}; word loads ignore SignExt.
REQ-027 RdData SHALL update only in DONE of a load; stores leave RdData unchanged.
REQ-028 Latency SHALL be: Done asserted 2 cycles after the Start edge for a byte access and 3 cycles after for a word access.
REQ-029 Start while Busy==1 SHALL be ignored, with no queuing; Start asserted in the DONE cycle is also ignored.
REQ-030 MemRead and MemWrite SHALL never be 1 simultaneously, and both SHALL be 0 in IDLE and DONE.
REQ-031 In IDLE and DONE, DataAddress, Byte and MemDataIn SHALL hold their last driven values.
REQ-032 Inputs other than Start SHALL be don't-care after capture; changes mid-access SHALL not affect the access.

Reset
REQ-033 Reset==0 SHALL immediately, without waiting for a clock edge, force state IDLE and drive Busy, Done, MemRead, MemWrite, Byte=0, DataAddress=0, MemDataIn=0 and RdData=0.
REQ-034 A reset mid-access SHALL abort the access; a word store aborted after LO leaves only the low byte written.
REQ-035 The first Start honoured after reset release SHALL be one sampled on the first rising edge with Reset==1.

Verification
REQ-036 Word store Addr=8'h10, WrData=16'hBEEF -> LO writes 8'hEF at 10 (Byte=0), HI writes 8'hBE at 11 (Byte=1), Done at cycle 3.
REQ-037 Word load from 8'h10 after REQ-036 -> RdData=16'hBEEF, Done 3 cycles after Start, MemWrite never asserted.
REQ-038 Byte load of 8'h80 with SignExt=1 -> RdData=16'hFF80; with SignExt=0 -> 16'h0080; Done 2 cycles after Start.
REQ-039 Word store at Addr=8'hFF, WrData=16'h1234 -> 8'h34 at FF, 8'h12 at 00; load back returns 16'h1234.
REQ-040 Start pulsed every cycle during a word store -> exactly one access and one Done pulse; MemRead&MemWrite never both 1.
REQ-041 Reset driven low in HI of a word store -> all outputs 0 with no clock edge, memory high byte unwritten, FSM in IDLE.
